// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: framing constants, state encoding
// and the clocks-per-bit helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

  function automatic int unsigned clk_per_bit(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART signal bundle: serial line in, received byte and status strobes out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx_pin;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;

  // master is the receiver itself; slave is whatever consumes the bytes.
  modport master (input rx_pin, output rx_data, output rx_valid, output rx_busy,
                  output frame_err);
  modport slave (output rx_pin, input rx_data, input rx_valid, input rx_busy,
                 input frame_err);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input with a configurable reset level.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_pin, samples each bit at its midpoint and emits one-cycle
// rx_valid / frame_err strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 5000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT    = CLK_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST    = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST   = 16'(HALF_BIT - 1);
  localparam logic [2:0]  IDX_LAST    = 3'(DATA_BITS - 1);

  if (CLK_PER_BIT < 4 || CLK_PER_BIT > 65535) begin : g_cfg_check
    $fatal(1, "uart_rx: CLK_PER_BIT out of range 4..65535");
  end

  logic rx_s;

  uart_rx_sync #(
    .RESET_VAL(IDLE_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(bus.rx_pin),
    .q_o(rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [15:0]          clk_count_q, clk_count_d;
  logic [2:0]           bit_index_q, bit_index_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d     = START;
          clk_count_d = '0;
        end
      end
      START: begin
        if (clk_count_q == HALF_LAST) begin
          // A high line at the start-bit midpoint means the falling edge was a glitch.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d     = DATA;
            clk_count_d = '0;
            bit_index_d = '0;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_count_q == BIT_LAST) begin
          clk_count_d = '0;
          shift_d     = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_index_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_count_q == BIT_LAST) begin
          clk_count_d = '0;
          if (rx_s) begin
            // Back to IDLE at the stop midpoint so a zero-gap next frame is caught.
            state_d    = IDLE;
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d     = WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit (CLK_FREQ=160, BAUD_RATE=10).
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ(160),
    .BAUD_RATE(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int busy_cnt  = 0;
  int wide_cnt  = 0;
  int both_cnt  = 0;
  logic prev_valid = 1'b0;
  logic [7:0] data_q [$];

  int vb, fb, bb, qb, n81;

  // Event observer: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      valid_cnt++;
      data_q.push_back(bus.rx_data);
      if (prev_valid) wide_cnt++;
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    if (bus.rx_busy === 1'b1) busy_cnt++;
    prev_valid = (bus.rx_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int cpb);
    bus.rx_pin = v;
    ticks(cpb);
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_v);
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(b[i], cpb);
    drive_bit(stop_v, cpb);
  endtask

  task automatic snap();
    vb = valid_cnt;
    fb = ferr_cnt;
    bb = busy_cnt;
    qb = data_q.size();
  endtask

  initial begin
    bus.rx_pin = 1'b1;
    rst = 1'b1;
    ticks(3);
    #1;
    check("rst_data", 32'(bus.rx_data), 32'h00);
    check("rst_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_busy", 32'(bus.rx_busy), 32'h0);
    check("rst_ferr", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;
    ticks(2);

    // Single frame A5: START 8 + DATA 8*16 + STOP 16 = 152 busy cycles.
    snap();
    send_byte(8'hA5, CPB, 1'b1);
    ticks(20);
    #1;
    check("a5_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check("a5_data_q", 32'(data_q[qb]), 32'hA5);
    check("a5_rx_data", 32'(bus.rx_data), 32'hA5);
    check("a5_ferr", 32'(ferr_cnt - fb), 32'd0);
    check("a5_busy_len", 32'(busy_cnt - bb), 32'd152);
    check("a5_busy_end", 32'(bus.rx_busy), 32'h0);

    // Back-to-back frames with no idle gap.
    snap();
    send_byte(8'h00, CPB, 1'b1);
    send_byte(8'hFF, CPB, 1'b1);
    send_byte(8'h55, CPB, 1'b1);
    ticks(20);
    #1;
    check("b2b_valid_cnt", 32'(valid_cnt - vb), 32'd3);
    check("b2b_byte0", 32'(data_q[qb]), 32'h00);
    check("b2b_byte1", 32'(data_q[qb + 1]), 32'hFF);
    check("b2b_byte2", 32'(data_q[qb + 2]), 32'h55);
    check("b2b_ferr", 32'(ferr_cnt - fb), 32'd0);

    // Five-clock glitch: busy only through the START half bit.
    snap();
    bus.rx_pin = 1'b0;
    ticks(5);
    bus.rx_pin = 1'b1;
    ticks(30);
    #1;
    check("glitch_valid", 32'(valid_cnt - vb), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - fb), 32'd0);
    check("glitch_busy_len", 32'(busy_cnt - bb), 32'd8);
    check("glitch_busy_end", 32'(bus.rx_busy), 32'h0);

    // Framing error with line held low (break), then released.
    snap();
    send_byte(8'h3C, CPB, 1'b0);
    ticks(40);
    #1;
    check("ferr_pulse", 32'(ferr_cnt - fb), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - vb), 32'd0);
    check("ferr_busy_hold", 32'(bus.rx_busy), 32'h1);
    check("ferr_data_kept", 32'(bus.rx_data), 32'h55);
    bus.rx_pin = 1'b1;
    ticks(200);
    #1;
    check("ferr_busy_end", 32'(bus.rx_busy), 32'h0);
    check("ferr_no_restart", 32'(valid_cnt - vb), 32'd0);
    check("ferr_single", 32'(ferr_cnt - fb), 32'd1);

    // Reset during bit 4 of 81, then a clean 7E.
    snap();
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i), CPB);
    bus.rx_pin = 1'b0;
    ticks(4);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    #1;
    check("mid_rst_data", 32'(bus.rx_data), 32'h00);
    check("mid_rst_valid", 32'(bus.rx_valid), 32'h0);
    check("mid_rst_busy", 32'(bus.rx_busy), 32'h0);
    check("mid_rst_ferr", 32'(bus.frame_err), 32'h0);
    ticks(11);
    for (int i = 5; i < 8; i++) drive_bit(1'(8'h81 >> i), CPB);
    drive_bit(1'b1, CPB);
    ticks(400);
    send_byte(8'h7E, CPB, 1'b1);
    ticks(20);
    #1;
    n81 = 0;
    for (int i = qb; i < data_q.size(); i++) if (data_q[i] == 8'h81) n81++;
    check("rst_no_81", 32'(n81), 32'd0);
    check("rst_last_7e", 32'(data_q[data_q.size() - 1]), 32'h7E);
    check("rst_rx_data_7e", 32'(bus.rx_data), 32'h7E);
    check("rst_ferr", 32'(ferr_cnt - fb), 32'd0);

    // Baud mismatch: C3 at 15 and 17 clocks per bit.
    snap();
    send_byte(8'hC3, 15, 1'b1);
    ticks(40);
    #1;
    check("fast_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check("fast_data", 32'(data_q[qb]), 32'hC3);
    check("fast_ferr", 32'(ferr_cnt - fb), 32'd0);
    snap();
    send_byte(8'hC3, 17, 1'b1);
    ticks(40);
    #1;
    check("slow_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check("slow_data", 32'(data_q[qb]), 32'hC3);
    check("slow_ferr", 32'(ferr_cnt - fb), 32'd0);
    check("slow_rx_data", 32'(bus.rx_data), 32'hC3);

    check("valid_one_cycle", 32'(wide_cnt), 32'd0);
    check("valid_ferr_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the team's UART transmitter: 8N1 framing, LSB first, idle-high line, same CLK_FREQ/BAUD_RATE scheme.
- Synchronizes the asynchronous rx_pin and detects the start bit.
- Samples each bit at its nominal midpoint and presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the command/LCD-control logic.

Parameters:
- CLK_FREQ, 5000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- Derived constants, not overridable:
  - CLK_PER_BIT = CLK_FREQ / BAUD_RATE (integer division; 520 at defaults).
  - HALF_BIT = CLK_PER_BIT / 2.
  - Elaboration check requires 4 <= CLK_PER_BIT <= 65535.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_pin  in  1  asynchronous serial input, idle high.
- rx_data  out  8  last correctly framed byte; held until the next good byte.
- rx_valid  out  1  one-cycle pulse: rx_data updated this cycle.
- rx_busy  out  1  high while a frame is being received (states other than IDLE).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On rst high at a clk edge: state=IDLE, counters=0, shift=0.
  - Outputs: rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0.
  - Both synchronizer flops are set to 1 (line idle).
  - rst mid-frame abandons the frame; no rx_valid or frame_err is produced.
- Synchronizer: 2 flops. rx_s is the second flop; all decisions use rx_s only.
- clk_count is 16 bits; bit_index is 3 bits.
- IDLE:
  - rx_s == 0 -> START, clk_count=0.
- START:
  - clk_count increments each cycle.
  - At clk_count == HALF_BIT-1 (start-bit midpoint), sample rx_s:
    - rx_s == 1: glitch; return to IDLE, no outputs.
    - rx_s == 0: go to DATA, clk_count=0, bit_index=0.
- DATA:
  - Sample when clk_count == CLK_PER_BIT-1, then clk_count=0.
  - Each sample shifts into shift[7] with a right shift, so bit 0 arrives first and the byte ends up LSB-correct.
  - After the sample with bit_index == 7, go to STOP; otherwise bit_index+1.
- STOP:
  - Sample at clk_count == CLK_PER_BIT-1.
  - rx_s == 1: rx_data <= shift and rx_valid=1 on the next edge (single cycle); go to IDLE immediately, so the next start bit is detectable from the stop-bit midpoint onward.
  - rx_s == 0: frame_err=1 for one cycle; rx_data unchanged; go to WAIT_IDLE.
- WAIT_IDLE (break/framing recovery):
  - Stay until rx_s == 1, then go to IDLE.
  - No start detection while in this state.
- rx_valid and frame_err are never high in the same cycle. Both are registered and default to 0 every cycle.
- Latency:
  - Falling edge on rx_pin to START entry: 2–3 cycles (synchronizer).
  - rx_valid rises 1 cycle after the stop-bit sample, about 9.5 bit times after the start edge.
- Back-to-back frames with zero idle gap must be received without loss.
- Baud tolerance: up to ±2% combined clock mismatch must receive correctly.

Decomposition:
- Package uart_pkg holds:
  - Function clk_per_bit(clk_freq, baud).
  - DATA_BITS=8.
  - State encoding constants IDLE/START/DATA/STOP/WAIT_IDLE (3-bit).
  - Idle line level constant.
- The package is shared with the existing transmitter.
- One sub-module: uart_rx_sync, a 2-flop synchronizer with a reset value parameter (reset to 1 here).

Test Plan (CLK_FREQ=160, BAUD_RATE=10 -> CLK_PER_BIT=16, HALF_BIT=8):
- Send 8'hA5 with 16 clocks/bit:
  - rx_valid pulses exactly once, 1 cycle wide.
  - rx_data=8'hA5; frame_err stays 0.
  - rx_busy high from START entry until the stop sample.
- Send 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap -> three rx_valid pulses carrying 00, FF, 55 in order.
- Pull rx_pin low for 5 clocks, then high -> no rx_valid and no frame_err; rx_busy returns to 0 at the START midpoint sample.
- Frame 8'h3C with stop bit driven 0, line held low 40 more clocks, then high:
  - frame_err pulses once; rx_data keeps the previous value.
  - No new start is detected until the line has been high again.
- Assert rst for 1 cycle during bit 4 of 8'h81, then send 8'h7E:
  - No output for 8'h81.
  - rx_valid with rx_data=8'h7E.
  - All outputs were 0/8'h00 after reset.
- Send 8'hC3 at 15 and at 17 clocks/bit (±6%, line stretched/compressed) -> rx_data=8'hC3 both times.
